// File: rtl/rwf_pkg.sv
// Shared helpers for ratio_width_fifo: log2, pointer widths and lane mapping.
package rwf_pkg;

  localparam int unsigned DEF_IN_W       = 32;
  localparam int unsigned DEF_RATIO      = 4;
  localparam int unsigned DEF_DEPTH_LOG2 = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned wr_ptr_w(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

  function automatic int unsigned rd_ptr_w(input int unsigned depth_log2,
                                           input int unsigned ratio);
    return depth_log2 + clog2(ratio) + 1;
  endfunction

  // Logical lane (emission order) to physical lane position in the word.
  function automatic int unsigned lane_map(input int unsigned lane,
                                           input int unsigned ratio,
                                           input bit          msb_first);
    return msb_first ? (ratio - 1 - lane) : lane;
  endfunction

endpackage

// File: rtl/simple_dual_port_dist_ram.sv
// Distributed RAM: one synchronous write port, one asynchronous read port, no reset.
module simple_dual_port_dist_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ratio_width_fifo.sv
// Wide-in / narrow-out FWFT FIFO with power-of-two width ratio.
// Optional sticky ovf/udf error flags when RWF_ERR_EN is defined.
module ratio_width_fifo
  import rwf_pkg::*;
#(
  parameter int unsigned IN_W             = DEF_IN_W,
  parameter int unsigned RATIO            = DEF_RATIO,
  parameter int unsigned OUT_W            = IN_W / RATIO,
  parameter int unsigned DEPTH_LOG2       = DEF_DEPTH_LOG2,
  parameter int unsigned ALMOST_EMPTY_CNT = 1,
  parameter int unsigned ALMOST_FULL_CNT  = 1,
  parameter bit          MSB_FIRST        = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [IN_W-1:0]                   d,
  output logic                              full,
  input  logic                              pop,
  output logic [OUT_W-1:0]                  q,
  output logic                              empty,
  output logic [DEPTH_LOG2:0]               count_in,
  output logic [DEPTH_LOG2+clog2(RATIO):0]  count_out,
  output logic                              almost_empty,
  output logic                              almost_full
`ifdef RWF_ERR_EN
  ,
  output logic                              ovf,
  output logic                              udf
`endif
);

  localparam int unsigned LR    = clog2(RATIO);
  localparam int unsigned WPW   = wr_ptr_w(DEPTH_LOG2);
  localparam int unsigned RPW   = rd_ptr_w(DEPTH_LOG2, RATIO);
  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [WPW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [RPW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WPW-1:0]  rd_word;
  logic            push_acc, pop_acc;
  logic [IN_W-1:0] rdata;

  // Occupancy and flags, all derived from the registered pointers.
  assign rd_word      = rd_ptr_q[RPW-1:LR];
  assign count_in     = wr_ptr_q - rd_word;
  assign count_out    = (RPW'(wr_ptr_q) << LR) - rd_ptr_q;
  assign empty        = (count_out == '0);
  assign full         = (count_in == WPW'(DEPTH));
  assign almost_empty = (32'(count_out) <= ALMOST_EMPTY_CNT);
  assign almost_full  = ((DEPTH - 32'(count_in)) <= ALMOST_FULL_CNT);

  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + WPW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + RPW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  simple_dual_port_dist_ram #(
    .DATA_W (IN_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (d),
    .raddr_i (rd_word[DEPTH_LOG2-1:0]),
    .rdata_o (rdata)
  );

  // Lane select: the low rd_ptr bits pick the lane of the head word.
  if (LR == 0) begin : g_no_lane
    assign q = rdata;
  end else begin : g_lane
    logic [OUT_W-1:0] lanes [RATIO];
    logic [LR-1:0]    phys;
    for (genvar g = 0; g < RATIO; g++) begin : g_split
      assign lanes[g] = rdata[g*OUT_W +: OUT_W];
    end
    assign phys = LR'(lane_map(32'(rd_ptr_q[LR-1:0]), RATIO, MSB_FIRST));
    assign q    = lanes[phys];
  end

`ifdef RWF_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push && full) ovf_q <= 1'b1;
      if (pop && empty) udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_ratio_width_fifo.sv
// Scoreboard bench for ratio_width_fifo: RATIO=2 LSB-first and RATIO=4 MSB-first instances.
module tb_ratio_width_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       push2, pop2, full2, empty2, ae2, af2;
  logic [7:0] d2;
  logic [3:0] q2;
  logic [2:0] cin2;
  logic [3:0] cout2;

  logic        push4, pop4, full4, empty4, ae4, af4;
  logic [15:0] d4;
  logic [3:0]  q4;
  logic [2:0]  cin4;
  logic [4:0]  cout4;

`ifdef RWF_ERR_EN
  logic ovf2, udf2, ovf4, udf4;
`endif

  ratio_width_fifo #(
    .IN_W(8), .RATIO(2), .DEPTH_LOG2(2), .MSB_FIRST(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .push(push2), .d(d2), .full(full2), .pop(pop2),
    .q(q2), .empty(empty2), .count_in(cin2), .count_out(cout2),
    .almost_empty(ae2), .almost_full(af2)
`ifdef RWF_ERR_EN
    , .ovf(ovf2), .udf(udf2)
`endif
  );

  ratio_width_fifo #(
    .IN_W(16), .RATIO(4), .DEPTH_LOG2(2), .MSB_FIRST(1'b1)
  ) dut4 (
    .clk(clk), .rst(rst), .push(push4), .d(d4), .full(full4), .pop(pop4),
    .q(q4), .empty(empty4), .count_in(cin4), .count_out(cout4),
    .almost_empty(ae4), .almost_full(af4)
`ifdef RWF_ERR_EN
    , .ovf(ovf4), .udf(udf4)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] sb2[$];
  logic [3:0] sb4[$];

  function automatic int unsigned words_of(input int unsigned lanes, input int unsigned r);
    return (lanes + r - 1) / r;
  endfunction

  // One clock of stimulus on the RATIO=2 instance; scoreboard follows accepted traffic.
  task automatic drv2(input logic p, input logic [7:0] din, input logic po);
    logic acc_p, acc_o;
    acc_p = p && (words_of(sb2.size(), 2) < 4);
    acc_o = po && (sb2.size() != 0);
    push2 = p; d2 = din; pop2 = po;
    @(posedge clk); #1;
    push2 = 1'b0; pop2 = 1'b0;
    if (acc_o) void'(sb2.pop_front());
    if (acc_p) begin
      sb2.push_back(din[3:0]);
      sb2.push_back(din[7:4]);
    end
  endtask

  // Same for the RATIO=4 MSB-first instance.
  task automatic drv4(input logic p, input logic [15:0] din, input logic po);
    logic acc_p, acc_o;
    acc_p = p && (words_of(sb4.size(), 4) < 4);
    acc_o = po && (sb4.size() != 0);
    push4 = p; d4 = din; pop4 = po;
    @(posedge clk); #1;
    push4 = 1'b0; pop4 = 1'b0;
    if (acc_o) void'(sb4.pop_front());
    if (acc_p) begin
      sb4.push_back(din[15:12]);
      sb4.push_back(din[11:8]);
      sb4.push_back(din[7:4]);
      sb4.push_back(din[3:0]);
    end
  endtask

  task automatic apply_reset(input logic with_traffic);
    rst = 1'b1;
    push2 = with_traffic; pop2 = with_traffic; d2 = 8'h99;
    push4 = with_traffic; pop4 = with_traffic; d4 = 16'h9999;
    @(posedge clk); #1;
    rst = 1'b0;
    push2 = 1'b0; pop2 = 1'b0; push4 = 1'b0; pop4 = 1'b0;
    sb2.delete();
    sb4.delete();
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    n_chk++; if (empty2 !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty2); end
    n_chk++; if (full2 !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full2); end
    n_chk++; if (cin2 !== 3'd0) begin n_fail++; $display("FAIL reset_count_in: got %0d expected 0", cin2); end
    n_chk++; if (cout2 !== 4'd0) begin n_fail++; $display("FAIL reset_count_out: got %0d expected 0", cout2); end
    n_chk++; if (ae2 !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b expected 1", ae2); end
    n_chk++; if (af2 !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b expected 0", af2); end
    n_chk++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL reset_empty4: got %b expected 1", empty4); end
`ifdef RWF_ERR_EN
    n_chk++; if (ovf2 !== 1'b0 || udf2 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", ovf2, udf2); end
`endif
  endtask

  task automatic test_single();
    drv2(1'b1, 8'hA5, 1'b0);
    n_chk++; if (empty2 !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", empty2); end
    n_chk++; if (q2 !== 4'h5) begin n_fail++; $display("FAIL single_q0: got %h expected 5", q2); end
    n_chk++; if (cout2 !== 4'd2) begin n_fail++; $display("FAIL single_count_out: got %0d expected 2", cout2); end
    n_chk++; if (ae2 !== 1'b0) begin n_fail++; $display("FAIL single_ae_clear: got %b expected 0", ae2); end
    drv2(1'b0, 8'h00, 1'b1);
    n_chk++; if (q2 !== 4'hA) begin n_fail++; $display("FAIL single_q1: got %h expected a", q2); end
    n_chk++; if (cin2 !== 3'd1) begin n_fail++; $display("FAIL single_count_in: got %0d expected 1", cin2); end
    n_chk++; if (ae2 !== 1'b1) begin n_fail++; $display("FAIL single_ae_set: got %b expected 1", ae2); end
    drv2(1'b0, 8'h00, 1'b1);
    n_chk++; if (empty2 !== 1'b1) begin n_fail++; $display("FAIL single_drained: got %b expected 1", empty2); end
    n_chk++; if (cin2 !== 3'd0) begin n_fail++; $display("FAIL single_count_in0: got %0d expected 0", cin2); end
    drv2(1'b0, 8'h00, 1'b1);
    n_chk++; if (empty2 !== 1'b1 || cout2 !== 4'd0) begin n_fail++; $display("FAIL pop_on_empty: got empty=%b cnt=%0d expected 1/0", empty2, cout2); end
`ifdef RWF_ERR_EN
    n_chk++; if (udf2 !== 1'b1) begin n_fail++; $display("FAIL udf_sticky: got %b expected 1", udf2); end
`endif
  endtask

  task automatic test_fill();
    logic [7:0] w [4];
    w[0] = 8'h10; w[1] = 8'h32; w[2] = 8'h54; w[3] = 8'h76;
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      drv2(1'b1, w[i], 1'b0);
      n_chk++; if (af2 !== (i >= 2)) begin n_fail++; $display("FAIL fill_almost_full%0d: got %b expected %b", i, af2, (i >= 2)); end
    end
    n_chk++; if (full2 !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full2); end
    n_chk++; if (cin2 !== 3'd4) begin n_fail++; $display("FAIL fill_count_in: got %0d expected 4", cin2); end
    n_chk++; if (cout2 !== 4'd8) begin n_fail++; $display("FAIL fill_count_out: got %0d expected 8", cout2); end
    drv2(1'b1, 8'hFF, 1'b0);
    n_chk++; if (cin2 !== 3'd4 || cout2 !== 4'd8) begin n_fail++; $display("FAIL fill_drop: got %0d/%0d expected 4/8", cin2, cout2); end
`ifdef RWF_ERR_EN
    n_chk++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf2); end
`endif
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (q2 !== 4'(i) || q2 !== sb2[0]) begin n_fail++; $display("FAIL fill_order%0d: got %h expected %h", i, q2, 4'(i)); end
      drv2(1'b0, 8'h00, 1'b1);
    end
    n_chk++; if (empty2 !== 1'b1) begin n_fail++; $display("FAIL fill_empty_after: got %b expected 1", empty2); end
  endtask

  task automatic test_full_release();
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) drv2(1'b1, 8'(8'h21 * (i + 1)), 1'b0);
    drv2(1'b0, 8'h00, 1'b1);
    n_chk++; if (full2 !== 1'b1 || cin2 !== 3'd4) begin n_fail++; $display("FAIL half_word_full: got full=%b cin=%0d expected 1/4", full2, cin2); end
    n_chk++; if (cout2 !== 4'd7) begin n_fail++; $display("FAIL half_word_cout: got %0d expected 7", cout2); end
    drv2(1'b0, 8'h00, 1'b1);
    n_chk++; if (full2 !== 1'b0 || cin2 !== 3'd3) begin n_fail++; $display("FAIL word_release: got full=%b cin=%0d expected 0/3", full2, cin2); end
    n_chk++; if (af2 !== 1'b1) begin n_fail++; $display("FAIL release_af: got %b expected 1", af2); end
    drv2(1'b1, 8'hC3, 1'b0);
    n_chk++; if (full2 !== 1'b1) begin n_fail++; $display("FAIL refill_full: got %b expected 1", full2); end
    drv2(1'b1, 8'hEE, 1'b1);
    n_chk++; if (cout2 !== 4'd7 || cin2 !== 3'd4) begin n_fail++; $display("FAIL push_pop_on_full: got cout=%0d cin=%0d expected 7/4", cout2, cin2); end
    for (int k = 0; k < 16 && sb2.size() != 0; k++) begin
      n_chk++; if (q2 !== sb2[0]) begin n_fail++; $display("FAIL release_drain%0d: got %h expected %h", k, q2, sb2[0]); end
      drv2(1'b0, 8'h00, 1'b1);
    end
    n_chk++; if (empty2 !== 1'b1) begin n_fail++; $display("FAIL release_empty: got %b expected 1", empty2); end
  endtask

  task automatic test_stream2();
    int pushed;
    logic p;
    apply_reset(1'b0);
    pushed = 0;
    for (int cyc = 0; cyc < 200 && (pushed < 20 || sb2.size() != 0); cyc++) begin
      n_chk++; if (empty2 !== (sb2.size() == 0) || cout2 !== 4'(sb2.size())) begin n_fail++; $display("FAIL stream2_cnt%0d: got %b/%0d expected %b/%0d", cyc, empty2, cout2, (sb2.size() == 0), sb2.size()); end
      n_chk++; if (cin2 !== 3'(words_of(sb2.size(), 2)) || full2 !== (words_of(sb2.size(), 2) == 4)) begin n_fail++; $display("FAIL stream2_cin%0d: got %0d/%b expected %0d", cyc, cin2, full2, words_of(sb2.size(), 2)); end
      if (sb2.size() != 0) begin
        n_chk++; if (q2 !== sb2[0]) begin n_fail++; $display("FAIL stream2_q%0d: got %h expected %h", cyc, q2, sb2[0]); end
      end
      p = (pushed < 20) && (words_of(sb2.size(), 2) < 4);
      drv2(p, 8'(8'h40 + pushed), 1'b1);
      if (p) pushed++;
    end
    n_chk++; if (empty2 !== 1'b1 || pushed != 20) begin n_fail++; $display("FAIL stream2_end: got empty=%b pushed=%0d expected 1/20", empty2, pushed); end
  endtask

  task automatic test_stream4();
    int pushed;
    logic p;
    apply_reset(1'b0);
    drv4(1'b1, 16'h1234, 1'b0);
    n_chk++; if (cout4 !== 5'd4) begin n_fail++; $display("FAIL r4_count_out: got %0d expected 4", cout4); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (q4 !== 4'(k + 1)) begin n_fail++; $display("FAIL r4_msb_order%0d: got %h expected %h", k, q4, 4'(k + 1)); end
      drv4(1'b0, 16'h0000, 1'b1);
    end
    pushed = 0;
    for (int cyc = 0; cyc < 300 && (pushed < 20 || sb4.size() != 0); cyc++) begin
      n_chk++; if (empty4 !== (sb4.size() == 0) || cout4 !== 5'(sb4.size()) || cin4 !== 3'(words_of(sb4.size(), 4))) begin n_fail++; $display("FAIL stream4_cnt%0d: got %b/%0d/%0d expected size %0d", cyc, empty4, cout4, cin4, sb4.size()); end
      if (sb4.size() != 0) begin
        n_chk++; if (q4 !== sb4[0]) begin n_fail++; $display("FAIL stream4_q%0d: got %h expected %h", cyc, q4, sb4[0]); end
      end
      p = (pushed < 20) && (words_of(sb4.size(), 4) < 4);
      drv4(p, 16'(16'h0123 + pushed * 16'h1111), 1'b1);
      if (p) pushed++;
    end
    n_chk++; if (empty4 !== 1'b1 || pushed != 20) begin n_fail++; $display("FAIL stream4_end: got empty=%b pushed=%0d expected 1/20", empty4, pushed); end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    drv2(1'b1, 8'h11, 1'b0);
    drv2(1'b1, 8'h22, 1'b1);
    drv2(1'b1, 8'h33, 1'b1);
    drv4(1'b1, 16'hABCD, 1'b0);
    apply_reset(1'b1);
    n_chk++; if (empty2 !== 1'b1 || full2 !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got %b%b expected 10", empty2, full2); end
    n_chk++; if (cin2 !== 3'd0 || cout2 !== 4'd0) begin n_fail++; $display("FAIL midrst_counts: got %0d/%0d expected 0/0", cin2, cout2); end
    n_chk++; if (ae2 !== 1'b1 || af2 !== 1'b0) begin n_fail++; $display("FAIL midrst_almost: got %b%b expected 10", ae2, af2); end
    n_chk++; if (empty4 !== 1'b1 || cout4 !== 5'd0) begin n_fail++; $display("FAIL midrst_r4: got %b/%0d expected 1/0", empty4, cout4); end
    drv2(1'b1, 8'h3C, 1'b0);
    n_chk++; if (empty2 !== 1'b0 || q2 !== 4'hC || cin2 !== 3'd1) begin n_fail++; $display("FAIL midrst_push: got %b/%h/%0d expected 0/c/1", empty2, q2, cin2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    push2 = 1'b0; pop2 = 1'b0; d2 = '0;
    push4 = 1'b0; pop4 = 1'b0; d4 = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_fill();
    test_full_release();
    test_stream2();
    test_stream4();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
